led_scan_ctrl: RTL and testbench

Time-multiplexes one shared registered hex-to-7-segment decoder across NUM_DIGITS common-anode digits, so the MIDI front panel needs only one decoder. Accepts a multi-nibble display value over a valid/ready handshake and holds it in a pending register. Sequences decoder loads, per-digit enables, inter-digit blanking and optional leading-zero suppression. The display value changes only on frame boundaries, so a frame never mixes old and new nibbles.

---
 rtl/led_scan_ctrl_if.sv | 10 +
 rtl/led_scan_ctrl.sv | 100 ++++++++++
 tb/tb_led_scan_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_scan_ctrl_if.sv
// led_scan_ctrl_if: display-value valid/ready handshake between panel logic and the scan controller
interface led_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value_in;
   logic                    value_valid;
   logic                    value_ready;
   modport master (output value_in, output value_valid, input value_ready);
   modport slave  (input value_in, input value_valid, output value_ready);
endinterface

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: scans one shared registered hex-to-7-segment decoder across multiplexed digits
module led_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   led_scan_ctrl_if.slave        vbus,
   input  logic                  lz_blank_en,
   output logic [3:0]            dec_data_out,
   output logic                  dec_valid_out,
   output logic [NUM_DIGITS-1:0] digit_en_n,
   output logic                  frame_done
);
   localparam int MAXC = CLK_DIV > BLANK_CYCLES ? CLK_DIV : BLANK_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int DW   = 4 * NUM_DIGITS;
   typedef enum logic [1:0] {LOAD, SETTLE, ON, BLANK} state_t;
   state_t                  state_q, state_d;
   logic                    run_q;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [DW-1:0]           disp_q, disp_d, pend_q, pend_d;
   logic                    full_q, full_d, supp_q, supp_d;
   logic [3:0]              data_q, data_d;
   logic                    dv_q, dv_d, fd_q, fd_d;
   logic [NUM_DIGITS-1:0]   en_n_q, en_n_d;
   logic                    accept;
   assign vbus.value_ready = ~full_q;
   assign dec_data_out     = data_q;
   assign dec_valid_out    = dv_q;
   assign digit_en_n       = en_n_q;
   assign frame_done       = fd_q;
   // Next slot state, pending/display transfer on the frame boundary (the frame_done cycle), and registered outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      accept  = vbus.value_valid & ~full_q;
      pend_d  = accept ? vbus.value_in : pend_q;
      full_d  = accept | (full_q & ~fd_q);
      disp_d  = fd_q && full_q ? pend_q : disp_q;
      if (run_q) begin
         case (state_q)
            LOAD:   state_d = SETTLE;
            SETTLE: begin
               state_d = ON;
               cnt_d   = '0;
            end
            ON: begin
               state_d = cnt_q == CW'(CLK_DIV - 1) ? BLANK : ON;
               cnt_d   = cnt_q == CW'(CLK_DIV - 1) ? '0 : cnt_q + 1'b1;
            end
            default: begin
               state_d = cnt_q == CW'(BLANK_CYCLES - 1) ? LOAD : BLANK;
               cnt_d   = cnt_q == CW'(BLANK_CYCLES - 1) ? '0 : cnt_q + 1'b1;
               idx_d   = cnt_q != CW'(BLANK_CYCLES - 1) ? idx_q :
                         idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
            end
         endcase
      end
      supp_d = state_d == LOAD ? (lz_blank_en && idx_d != '0 && (disp_d >> {idx_d, 2'b00}) == '0) : supp_q;
      data_d = state_d == LOAD ? disp_d[{idx_d, 2'b00} +: 4] : data_q;
      dv_d   = state_d == LOAD;
      en_n_d = state_d == ON && !supp_d ? ~(NUM_DIGITS'(1) << idx_d) : '1;
      fd_d   = state_d == BLANK && cnt_d == CW'(BLANK_CYCLES - 1) && idx_d == IW'(NUM_DIGITS - 1);
   end
   // State and output registers; run_q lets the first edge after reset present LOAD of digit 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LOAD;
         run_q   <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         disp_q  <= '0;
         pend_q  <= '0;
         full_q  <= 1'b0;
         supp_q  <= 1'b0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         en_n_q  <= '1;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         disp_q  <= disp_d;
         pend_q  <= pend_d;
         full_q  <= full_d;
         supp_q  <= supp_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         en_n_q  <= en_n_d;
         fd_q    <= fd_d;
      end
   end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: randomized scoreboard bench for led_scan_ctrl against a slot/frame timing model
module tb_led_scan_ctrl;
   localparam int ND = 4;
   localparam int CD = 4;
   localparam int BC = 2;
   localparam int SL = 2 + CD + BC;
   localparam int P  = ND * SL;
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          lz_blank_en = 1'b0;
   logic [3:0]    dec_data_out;
   logic          dec_valid_out;
   logic [ND-1:0] digit_en_n;
   logic          frame_done;
   int            tests = 0;
   int            fails = 0;
   int            t = -1;
   logic [15:0]   disp = '0;
   logic [15:0]   exp_q[$];
   logic          supp = 1'b0;
   led_scan_ctrl_if #(.NUM_DIGITS(ND)) vbus ();
   led_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .reset(reset), .vbus(vbus), .lz_blank_en(lz_blank_en),
      .dec_data_out(dec_data_out), .dec_valid_out(dec_valid_out),
      .digit_en_n(digit_en_n), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
      end
   endtask
   // Reference model: cycle index since reset release, displayed value per frame, one-deep pending queue
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         t = -1;
         disp = '0;
         exp_q.delete();
         supp = 1'b0;
      end else begin
         automatic bit rdy = exp_q.size() == 0;
         if (t >= 0 && t % P == P - 1 && !rdy) disp = exp_q.pop_front();
         if (vbus.value_valid && rdy) exp_q.push_back(vbus.value_in);
         t = t + 1;
         if (t % SL == 0) begin
            automatic int s = (t % P) / SL;
            supp = lz_blank_en && s != 0 && (disp >> (4 * s)) == 0;
         end
      end
   end
   // Monitor: compare every visible output on the falling edge
   always @(negedge clk) begin
      if (!reset || t < 0) begin
         chk("rst_valid", dec_valid_out, 0);
         chk("rst_data", dec_data_out, 0);
         chk("rst_en", digit_en_n, 4'hF);
         chk("rst_fd", frame_done, 0);
         chk("rst_ready", vbus.value_ready, 1);
      end else begin
         automatic int p = t % SL;
         automatic int s = (t % P) / SL;
         automatic logic [ND-1:0] em = '1;
         if (p >= 2 && p < 2 + CD && !supp) em[s] = 1'b0;
         chk("dec_valid", dec_valid_out, p == 0);
         if (p == 0) chk("dec_data", dec_data_out, disp[4*s +: 4]);
         chk("digit_en_n", digit_en_n, em);
         chk("one_hot", $countones(~digit_en_n) <= 1, 1);
         chk("frame_done", frame_done, t % P == P - 1);
         chk("ready", vbus.value_ready, exp_q.size() == 0);
      end
   end
   task automatic send(input logic [15:0] v);
      int n = 0;
      vbus.value_in = v;
      vbus.value_valid = 1'b1;
      @(negedge clk);
      while (!vbus.value_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 200) begin
         fails++;
         $display("FAIL send_timeout value %0h got ready=0 expected ready=1", v);
      end
      @(negedge clk);
      vbus.value_valid = 1'b0;
   endtask
   task automatic frames(input int f);
      repeat (f * P) @(negedge clk);
   endtask
   initial begin
      vbus.value_in = '0;
      vbus.value_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      send(16'h1A3F);
      send(16'hBEEF);
      frames(3);
      lz_blank_en = 1'b1;
      send(16'h0050);
      frames(2);
      send(16'h0000);
      frames(2);
      for (int i = 0; i < 25; i++) begin
         automatic logic [15:0] v = 16'($urandom);
         for (int k = 0; k < ND; k++) if ($urandom_range(0, 2) == 0) v[4*k +: 4] = 4'h0;
         repeat ($urandom_range(0, 40)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) lz_blank_en = 1'($urandom_range(0, 1));
         send(v);
      end
      frames(2);
      send(16'h1234);
      for (int n = 0; n < 4 * P && !(t % P == 2 * SL + 3); n++) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_en", digit_en_n, 4'hF);
      chk("async_valid", dec_valid_out, 0);
      chk("async_ready", vbus.value_ready, 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      frames(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog got no finish expected finish");
      $fatal(1, "watchdog");
   end
endmodule
